// File: rtl/rtc_pkg.sv
// RTC register map, poller/transfer FSM encodings and transfer request/response types,
// shared between the poller and the RTC slave.
package rtc_pkg;

  localparam logic [7:0] RTC_CMD_SEC  = 8'h00;
  localparam logic [7:0] RTC_CMD_MIN  = 8'h02;
  localparam logic [7:0] RTC_CMD_HOUR = 8'h04;

  typedef logic [1:0] fld_t;
  localparam fld_t FLD_SEC  = 2'd0;
  localparam fld_t FLD_MIN  = 2'd1;
  localparam fld_t FLD_HOUR = 2'd2;
  localparam fld_t FLD_SEC2 = 2'd3;  // seconds re-read for the coherency check

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} rtc_state_e;
  typedef enum logic [1:0] {X_IDLE, X_BUS, X_GAP} xfer_state_e;

  typedef struct packed {
    logic       go;
    logic       we;
    logic [7:0] cmd;
  } xfer_req_t;

  typedef struct packed {
    logic        done;
    logic        err;
    logic [15:0] rdata;
  } xfer_rsp_t;

  function automatic logic [7:0] fld_cmd(input fld_t f);
    case (f)
      FLD_MIN:  fld_cmd = RTC_CMD_MIN;
      FLD_HOUR: fld_cmd = RTC_CMD_HOUR;
      default:  fld_cmd = RTC_CMD_SEC;
    endcase
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone single transfer: strobe held until ack, a mandatory idle GAP cycle afterwards,
// and an abort after TIMEOUT_CYCLES strobe cycles without ack.
module wb_single_xfer
  import rtc_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ADDR           = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  xfer_req_t   req_i,
  output xfer_rsp_t   rsp_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  xfer_state_e      state_q;
  logic             cyc_q, we_q, done_q, err_q;
  logic [7:0]       cmd_q;
  logic [15:0]      rdata_q;
  logic [TMO_W-1:0] tmo_q;
  logic             unused_dat;

  assign unused_dat = ^dat_i[31:16];

  // A new request is accepted from IDLE or straight out of GAP so fields run back to back;
  // the slave's lingering ack during GAP is never looked at.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= X_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cmd_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        X_BUS: begin
          if (ack_i) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= dat_i[15:0];
            state_q <= X_GAP;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= X_GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          if (req_i.go) begin
            state_q <= X_BUS;
            cyc_q   <= 1'b1;
            we_q    <= req_i.we;
            cmd_q   <= req_i.cmd;
            tmo_q   <= '0;
          end else begin
            state_q <= X_IDLE;
          end
        end
      endcase
    end
  end

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o  = cyc_q & we_q;
  assign sel_o = !cyc_q ? 4'b0000 : (we_q ? 4'b0001 : 4'b0011);
  assign adr_o = ADDR;
  assign dat_o = {24'b0, cmd_q};
  assign rsp_o = '{done: done_q, err: err_q, rdata: rdata_q};

endmodule

// File: rtl/rtc_poller.sv
// Periodic Wishbone snapshot of the RTC seconds/minutes/hours (BCD) via wb_single_xfer.
// `RTC_POLL_COHERENT_EN adds a seconds re-read with up to two restarts on rollover.
module rtc_poller
  import rtc_pkg::*;
#(
  parameter int          CLOCK_FREQ     = 50000000,
  parameter int          POLL_CYCLES    = 5000000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RTC_BASE       = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        start_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic [7:0]  second_o,
  output logic [7:0]  minute_o,
  output logic [7:0]  hour_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(POLL_CYCLES);
`ifdef RTC_POLL_COHERENT_EN
  localparam fld_t LAST_FLD = FLD_SEC2;
`else
  localparam fld_t LAST_FLD = FLD_HOUR;
`endif

  rtc_state_e       state_q;
  fld_t             fld_q, nxt_fld;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       retry_q;
  logic [7:0]       sec_sh_q, min_sh_q, hour_sh_q, sec_q, min_q, hour_q, hour_commit;
  logic             valid_q, err_q;
  logic             trig, echo_ok, last, mism, rd_ok, advance, restart, commit, fail;
  logic             unused_cfg;
  xfer_req_t        req;
  xfer_rsp_t        rsp;

  assign unused_cfg = (CLOCK_FREQ > 0);

  wb_single_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADDR(RTC_BASE)) u_xfer (
    .clk_i, .rst_i, .req_i(req), .rsp_o(rsp),
    .cyc_o, .stb_o, .we_o, .sel_o, .adr_o, .dat_o, .dat_i, .ack_i
  );

  always_comb begin
    trig    = (state_q == ST_IDLE) &&
              (start_i || (enable_i && cnt_q == CNT_W'(POLL_CYCLES - 1)));
    echo_ok = rsp.rdata[7:0] == fld_cmd(fld_q);
    last    = fld_q == LAST_FLD;
    mism    = 1'b0;
`ifdef RTC_POLL_COHERENT_EN
    mism    = rsp.rdata[15:8] != sec_sh_q;
`endif
    rd_ok   = (state_q == ST_RD) && rsp.done && echo_ok;
    advance = rd_ok && !last;
    commit  = rd_ok && last && !mism;
    restart = rd_ok && last && mism && (retry_q != 2'd2);
    fail    = ((state_q != ST_IDLE) && rsp.err) ||
              ((state_q == ST_RD) && rsp.done && !echo_ok) ||
              (rd_ok && last && mism && (retry_q == 2'd2));
    nxt_fld = restart ? FLD_SEC : fld_q + 2'd1;
    hour_commit = (LAST_FLD == FLD_HOUR) ? rsp.rdata[15:8] : hour_sh_q;

    // Next request is issued in the GAP cycle so the following strobe starts right after it.
    req.go  = 1'b0;
    req.we  = 1'b1;
    req.cmd = fld_cmd(nxt_fld);
    case (state_q)
      ST_IDLE: begin req.go = trig; req.cmd = RTC_CMD_SEC; end
      ST_WR:   begin req.go = rsp.done; req.we = 1'b0; req.cmd = fld_cmd(fld_q); end
      ST_RD:   req.go = advance || restart;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      fld_q     <= FLD_SEC;
      cnt_q     <= '0;
      retry_q   <= '0;
      sec_sh_q  <= '0;
      min_sh_q  <= '0;
      hour_sh_q <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fail)         err_q <= 1'b1;
      else if (start_i) err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q <= ST_WR;
            fld_q   <= FLD_SEC;
            retry_q <= '0;
            cnt_q   <= '0;
          end else if (enable_i) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WR: begin
          if (rsp.err)       state_q <= ST_IDLE;
          else if (rsp.done) state_q <= ST_RD;
        end
        ST_RD: begin
          if (rd_ok) begin
            case (fld_q)
              FLD_SEC:  sec_sh_q  <= rsp.rdata[15:8];
              FLD_MIN:  min_sh_q  <= rsp.rdata[15:8];
              FLD_HOUR: hour_sh_q <= rsp.rdata[15:8];
              default:  ;
            endcase
          end
          if (fail) begin
            state_q <= ST_IDLE;
          end else if (advance) begin
            fld_q   <= nxt_fld;
            state_q <= ST_WR;
          end else if (restart) begin
            fld_q   <= FLD_SEC;
            retry_q <= retry_q + 2'd1;
            state_q <= ST_WR;
          end else if (commit) begin
            sec_q   <= sec_sh_q;
            min_q   <= min_sh_q;
            hour_q  <= hour_commit;
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign second_o = sec_q;
  assign minute_o = min_q;
  assign hour_o   = hour_q;
  assign valid_o  = valid_q;
  assign busy_o   = state_q != ST_IDLE;
  assign err_o    = err_q;

endmodule

// File: tb/tb_rtc_poller.sv
// Scoreboard bench for rtc_poller against a registered-ack RTC slave model.
module tb_rtc_poller;

  localparam int POLL = 100;
`ifdef RTC_POLL_COHERENT_EN
  localparam int LAT = 24;
`else
  localparam int LAT = 18;
`endif

  logic        clk_i = 1'b0, rst_i = 1'b0, enable_i = 1'b0, start_i = 1'b0;
  logic        cyc_o, stb_o, we_o, ack_i, valid_o, busy_o, err_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [7:0]  second_o, minute_o, hour_o;

  rtc_poller #(.POLL_CYCLES(POLL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .start_i(start_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
    .second_o(second_o), .minute_o(minute_o), .hour_o(hour_o),
    .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] s, m, h; int lat; int per; } snap_t;
  typedef struct { logic we; logic [3:0] sel; logic [7:0] dat; } bus_t;

  snap_t exp_q[$];
  bus_t  bus_q[$];
  int    n_cmp = 0, n_err = 0, n_valid = 0, cyc = 0;
  bit    bus_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Slave model: ack registered from cyc&stb, so it arrives one cycle late and lingers one cycle.
  logic [7:0] sec_val = 8'h37, min_val = 8'h12, hour_val = 8'h09, cmd_reg;
  bit         block_min = 0, bad_echo = 0, coh = 0;
  int         sec_reads = 0, sec_base = 0;

  function automatic logic [7:0] rd_val(input logic [7:0] c);
    case (c)
      8'h00:   rd_val = (coh && sec_reads == sec_base) ? 8'h59 : sec_val;
      8'h02:   rd_val = min_val;
      default: rd_val = hour_val;
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_i   <= 1'b0;
      dat_i   <= '0;
      cmd_reg <= '0;
    end else begin
      ack_i <= cyc_o && stb_o && !(block_min && we_o && dat_o[7:0] == 8'h02);
      if (cyc_o && stb_o && we_o) cmd_reg <= dat_o[7:0];
      if (cyc_o && stb_o && !we_o)
        dat_i <= {16'h0, rd_val(cmd_reg), (bad_echo && cmd_reg == 8'h02) ? 8'h04 : cmd_reg};
      if (cyc_o && stb_o && !we_o && ack_i && cmd_reg == 8'h00) sec_reads <= sec_reads + 1;
    end
  end

  // Monitor: pops expected bus transfers and snapshots whenever the DUT presents them.
  logic  stb_prev = 1'b0, ackstb_prev = 1'b0;
  bit    in_snap = 0;
  int    snap_start = 0, last_valid = 0;
  snap_t e;
  bus_t  b;

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (stb_o && !stb_prev && !in_snap) begin in_snap = 1; snap_start = cyc; end
      if (ackstb_prev) chk("gap_after_ack", stb_o, 0);
      if (bus_chk && stb_o && ack_i) begin
        if (bus_q.size() == 0) chk("bus_extra_xfer", 1, 0);
        else begin
          b = bus_q.pop_front();
          chk("bus_we", we_o, b.we);
          chk("bus_sel", sel_o, b.sel);
          chk("bus_dat", dat_o, {24'h0, b.dat});
        end
      end
      if (valid_o) begin
        n_valid++;
        if (exp_q.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("second", second_o, e.s);
          chk("minute", minute_o, e.m);
          chk("hour", hour_o, e.h);
          chk("latency", cyc - snap_start, e.lat);
          if (e.per != 0) chk("poll_period", cyc - last_valid, e.per);
        end
        last_valid = cyc;
      end
      if (!busy_o) in_snap = 0;
    end
    stb_prev    = stb_o;
    ackstb_prev = stb_o && ack_i;
  end

  task automatic start_pulse();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_o && k < 3000) begin @(negedge clk_i); k++; end
    chk(name, busy_o, 0);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic push_snap(input logic [7:0] s, m, h, input int lat, per);
    snap_t x;
    x.s = s; x.m = m; x.h = h; x.lat = lat; x.per = per;
    exp_q.push_back(x);
  endtask

  task automatic push_bus(input logic [7:0] c);
    bus_t x;
    x.we = 1'b1; x.sel = 4'b0001; x.dat = c; bus_q.push_back(x);
    x.we = 1'b0; x.sel = 4'b0011; bus_q.push_back(x);
  endtask

  initial begin
    int nv0, n, k;
    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_outs", {second_o, minute_o, hour_o}, 0);
    chk("rst_flags", {valid_o, busy_o, err_o}, 0);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Basic snapshot with bus trace
    push_snap(8'h37, 8'h12, 8'h09, LAT, 0);
    push_bus(8'h00); push_bus(8'h02); push_bus(8'h04);
`ifdef RTC_POLL_COHERENT_EN
    push_bus(8'h00);
`endif
    bus_chk = 1;
    start_pulse();
    wait_idle("idle_basic");
    bus_chk = 0;
    chk("err_basic", err_o, 0);

    // Minute write never acked: timeout after 255 strobe cycles
    block_min = 1; nv0 = n_valid; n = 0; k = 0;
    start_pulse();
    while (busy_o && k < 3000) begin
      if (cyc_o && we_o && dat_o[7:0] == 8'h02) n++;
      @(negedge clk_i); k++;
    end
    chk("tmo_bound", busy_o, 0);
    chk("tmo_cycles", n, 255);
    chk("tmo_err", err_o, 1);
    chk("tmo_outs", {second_o, minute_o, hour_o}, 24'h371209);
    chk("tmo_no_valid", n_valid, nv0);
    block_min = 0; sec_val = 8'h38;
    push_snap(8'h38, 8'h12, 8'h09, LAT, 0);
    start_pulse();
    chk("err_cleared", err_o, 0);
    wait_idle("idle_recover");

    // Bad echo on the minute read
    bad_echo = 1; nv0 = n_valid;
    start_pulse();
    wait_idle("idle_echo");
    chk("echo_err", err_o, 1);
    chk("echo_outs", {second_o, minute_o, hour_o}, 24'h381209);
    chk("echo_no_valid", n_valid, nv0);
    bad_echo = 0;

    // Periodic polling, then enable dropped mid-snapshot
    nv0 = n_valid;
    push_snap(8'h38, 8'h12, 8'h09, LAT, 0);
    push_snap(8'h38, 8'h12, 8'h09, LAT, POLL + LAT);
    push_snap(8'h38, 8'h12, 8'h09, LAT, POLL + LAT);
    enable_i = 1'b1;
    k = 0;
    while (n_valid < nv0 + 2 && k < 1000) begin @(negedge clk_i); k++; end
    chk("poll_two_valids", n_valid, nv0 + 2);
    k = 0;
    while (!busy_o && k < 300) begin @(negedge clk_i); k++; end
    chk("poll_third_busy", busy_o, 1);
    enable_i = 1'b0;
    wait_idle("idle_poll");
    repeat (300) @(negedge clk_i);
    chk("poll_stopped", n_valid, nv0 + 3);

`ifdef RTC_POLL_COHERENT_EN
    // Seconds roll 59 -> 00 between reads: one restart, final snapshot uses 00
    coh = 1; sec_base = sec_reads; sec_val = 8'h00;
    push_snap(8'h00, 8'h12, 8'h09, 2 * LAT, 0);
    start_pulse();
    wait_idle("idle_coh");
    chk("coh_err", err_o, 0);
    coh = 0;
`endif

    // Reset asserted mid-read drops the bus and outputs at once
    nv0 = n_valid;
    start_pulse();
    k = 0;
    while (!(cyc_o && !we_o) && k < 100) begin @(negedge clk_i); k++; end
    chk("rd_reached", cyc_o && !we_o, 1);
    rst_i = 1'b0;
    #1;
    chk("async_cyc", {cyc_o, stb_o}, 0);
    chk("async_outs", {second_o, minute_o, hour_o}, 0);
    chk("async_flags", {valid_o, busy_o, err_o}, 0);
    @(negedge clk_i); rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("rst_no_valid", n_valid, nv0);

    chk("snap_queue_empty", exp_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
